wbu_regwrite: RTL and testbench
===============================

Name: wbu_regwrite

Overview:
- Writeback unit that drives the write side of the integer register file: `o_wen`, `o_waddr` and `o_wdata`.
- Accepts one retiring instruction per cycle from the EXU/LSU result stream through a valid/ready handshake and holds it in a single pipeline stage.
- Sign- or zero-extends load data, suppresses writes to x0, and reports commits.
- Keeps a per-register pending-write scoreboard that ID uses for RAW hazard stalls.

Parameters:
- CPU_WIDTH, 64, datapath width.
- REG_ADDRW, 5, register index width.
- REG_COUNT, 32, number of architectural registers.
- SB_CNTW, 2, width of each scoreboard pending counter (max in-flight writes per register = 2^SB_CNTW-1).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  upstream result valid.
- o_ready  output  1  stage can accept.
- i_rdwen  input  1  instruction writes rd.
- i_rdid  input  REG_ADDRW  destination register.
- i_is_load  input  1  result comes from the LSU (use i_ld_raw).
- i_ld_func3  input  3  load type: RISC-V funct3.
- i_alu_res  input  CPU_WIDTH  EXU result.
- i_ld_raw  input  CPU_WIDTH  LSU data, right-aligned.
- i_pc  input  CPU_WIDTH  instruction PC.
- i_stall  input  1  hold the staged entry (debug/sim halt).
- i_alloc  input  1  ID issues an instruction that will write rd.
- i_alloc_rd  input  REG_ADDRW  rd being allocated.
- o_alloc_ready  output  1  allocation permitted.
- o_busy_mask  output  REG_COUNT  bit i set = register i has a write pending.
- o_wen  output  1  regfile write enable.
- o_waddr  output  REG_ADDRW  regfile write address.
- o_wdata  output  CPU_WIDTH  regfile write data.
- o_commit_valid  output  1  one instruction retired this cycle.
- o_commit_pc  output  CPU_WIDTH  PC of the retiring instruction.
- o_instret  output  64  retired-instruction count (see optional feature).

Behaviour:
- Reset (async assert, sync-safe deassert): stage_valid=0, all scoreboard counters=0, o_instret=0.
  - Resulting outputs: o_wen=0, o_commit_valid=0, o_ready=1, o_busy_mask=0, o_alloc_ready=1.
  - o_waddr, o_wdata and o_commit_pc read 0 while stage_valid=0.
- Stage: one entry.
  - o_ready = !stage_valid || !i_stall.
  - A transfer (i_valid && o_ready) at edge N loads the stage.
  - Data is extended at load time, so the stage holds final wdata.
- Retire: stage_valid && !i_stall, combinational in the cycle after acceptance.
  - o_commit_valid=1 and o_commit_pc=stage pc.
  - o_wen = retire && rdwen && rd!=0.
  - The regfile captures the write at edge N+1, so latency from accept to register update is 1 cycle.
  - If retire and a new transfer happen in the same cycle, the stage is replaced with no bubble (throughput 1/cycle).
  - If retire happens with no transfer, stage_valid is cleared.
- i_stall=1 with the stage full: entry held, o_wen=0, o_commit_valid=0, o_ready=0.
- i_stall=1 with the stage empty: still accepts (o_ready=1).
- Load extension (i_is_load=1), by i_ld_func3:
  - 000: sext byte.
  - 001: sext half.
  - 010: sext word.
  - 011: pass 64 bits.
  - 100: zext byte.
  - 101: zext half.
  - 110: zext word.
  - 111: pass raw.
- i_is_load=0: wdata = i_alu_res; i_ld_func3 is ignored.
- x0:
  - Never written (o_wen=0 even if rdwen=1).
  - Never tracked: o_busy_mask[0] is always 0, and allocations to x0 are ignored.
- Scoreboard: one SB_CNTW-bit counter per register 1..REG_COUNT-1.
  - Increment on i_alloc && i_alloc_rd!=0 && o_alloc_ready.
  - Decrement when o_wen=1 for that register.
  - Simultaneous increment and decrement on the same register: counter unchanged.
  - o_alloc_ready = (counter[i_alloc_rd] != max) || (a decrement of i_alloc_rd happens this cycle) || (i_alloc_rd==0).
  - A decrement at 0 (write with no prior alloc) is ignored; the counter saturates at 0.
  - o_busy_mask[i] = counter[i]!=0, registered view. A pending write becomes non-busy the cycle after o_wen.

Optional Feature:
- Macro WBU_INSTRET_EN.
- When defined: 64-bit counter, reset to 0, +1 on every retire (including rdwen=0 and rd=0); wraps at 2^64-1 to 0. Drives o_instret.
- When undefined: no counter logic; o_instret tied to 0.

Test Plan:
- ALU write: accept rdwen=1, rd=5, alu_res=0x1234, pc=0x80000000, i_stall=0 -> next cycle o_wen=1, o_waddr=5, o_wdata=0x1234, o_commit_valid=1, o_commit_pc=0x80000000.
- Load extension: i_is_load=1, ld_raw=0x80 -> func3=000 gives 0xFFFFFFFFFFFFFF80; func3=100 gives 0x80. ld_raw=0x8000_0000 with func3=010 -> 0xFFFFFFFF80000000; with func3=110 -> 0x80000000.
- x0 suppression: rdwen=1, rd=0, alu_res=0xDEAD -> o_wen=0, o_commit_valid=1, o_busy_mask[0]=0; with WBU_INSTRET_EN, o_instret increments by 1.
- Stall: stage full and i_stall=1 for 3 cycles -> o_ready=0, o_wen=0 throughout. Release -> one write, then back-to-back transfers sustain 1 commit/cycle for 8 instructions.
- Scoreboard:
  - Alloc rd=7 three times (SB_CNTW=2) -> o_busy_mask[7]=1, o_alloc_ready=0 for rd=7.
  - A write to rd=7 in the same cycle as a 4th alloc -> alloc accepted, counter stays 3.
  - Three more writes -> o_busy_mask[7]=0.
- Reset mid-operation: with the stage full and counters nonzero, assert i_rst_n=0 asynchronously -> o_wen=0, o_commit_valid=0, o_busy_mask=0 and o_instret=0 immediately (no clock edge needed); o_ready=1 after release.

Source files
------------

// File: rtl/wbu_regwrite.sv
// wbu_regwrite: single-stage writeback unit driving the integer regfile write port
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid / o_ready       result-stream handshake into the single stage
//   i_rdwen, i_rdid         destination write enable and register index
//   i_is_load, i_ld_func3   select LSU data and its RISC-V load extension
//   i_alu_res, i_ld_raw     EXU result, right-aligned LSU data
//   i_pc                    PC of the incoming instruction
//   i_stall                 hold the staged entry
//   i_alloc, i_alloc_rd     ID allocation of a pending write to rd
//   o_alloc_ready           allocation permitted this cycle
//   o_busy_mask             per-register pending-write flags (bit 0 always 0)
//   o_wen, o_waddr, o_wdata regfile write port
//   o_commit_valid/_pc      retire report
//   o_instret               retired-instruction count, live only with WBU_INSTRET_EN defined
module wbu_regwrite #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5,
    parameter int REG_COUNT = 32,
    parameter int SB_CNTW   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_rdwen,
    input  logic [REG_ADDRW-1:0] i_rdid,
    input  logic                 i_is_load,
    input  logic [2:0]           i_ld_func3,
    input  logic [CPU_WIDTH-1:0] i_alu_res,
    input  logic [CPU_WIDTH-1:0] i_ld_raw,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic                 i_stall,
    input  logic                 i_alloc,
    input  logic [REG_ADDRW-1:0] i_alloc_rd,
    output logic                 o_alloc_ready,
    output logic [REG_COUNT-1:0] o_busy_mask,
    output logic                 o_wen,
    output logic [REG_ADDRW-1:0] o_waddr,
    output logic [CPU_WIDTH-1:0] o_wdata,
    output logic                 o_commit_valid,
    output logic [CPU_WIDTH-1:0] o_commit_pc,
    output logic [63:0]          o_instret
);
    localparam logic [SB_CNTW-1:0] CNT_MAX = '1;

    logic                 stage_valid;
    logic                 s_rdwen;
    logic [REG_ADDRW-1:0] s_rd;
    logic [CPU_WIDTH-1:0] s_wdata;
    logic [CPU_WIDTH-1:0] s_pc;
    logic [CPU_WIDTH-1:0] ext_data;
    logic                 retire;
    logic                 xfer;
    logic [REG_COUNT-1:0] inc;
    logic [REG_COUNT-1:0] dec;
    logic [SB_CNTW-1:0]   cnt     [REG_COUNT];
    logic [SB_CNTW-1:0]   cnt_nxt [REG_COUNT];

    // Extension happens on entry so the stage always holds final write data.
    always_comb begin
        ext_data = i_alu_res;
        if (i_is_load) begin
            case (i_ld_func3)
                3'b000:  ext_data = {{(CPU_WIDTH-8){i_ld_raw[7]}}, i_ld_raw[7:0]};
                3'b001:  ext_data = {{(CPU_WIDTH-16){i_ld_raw[15]}}, i_ld_raw[15:0]};
                3'b010:  ext_data = {{(CPU_WIDTH-32){i_ld_raw[31]}}, i_ld_raw[31:0]};
                3'b100:  ext_data = {{(CPU_WIDTH-8){1'b0}}, i_ld_raw[7:0]};
                3'b101:  ext_data = {{(CPU_WIDTH-16){1'b0}}, i_ld_raw[15:0]};
                3'b110:  ext_data = {{(CPU_WIDTH-32){1'b0}}, i_ld_raw[31:0]};
                default: ext_data = i_ld_raw;
            endcase
        end
    end

    assign retire         = stage_valid && !i_stall;
    assign o_ready        = !stage_valid || !i_stall;
    assign xfer           = i_valid && o_ready;
    assign o_wen          = retire && s_rdwen && (s_rd != '0);
    assign o_commit_valid = retire;
    assign o_waddr        = stage_valid ? s_rd : '0;
    assign o_wdata        = stage_valid ? s_wdata : '0;
    assign o_commit_pc    = stage_valid ? s_pc : '0;

    // A full counter may still take an allocation when this cycle's write frees a slot.
    assign o_alloc_ready = (i_alloc_rd == '0) || (cnt[i_alloc_rd] != CNT_MAX) ||
                           (o_wen && (s_rd == i_alloc_rd));

    // x0 never increments, and a write with nothing pending leaves the counter at 0.
    always_comb begin
        inc         = '0;
        dec         = '0;
        o_busy_mask = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            inc[r]         = (r != 0) && i_alloc && o_alloc_ready && (i_alloc_rd == REG_ADDRW'(r));
            dec[r]         = o_wen && (s_rd == REG_ADDRW'(r)) && (cnt[r] != '0);
            cnt_nxt[r]     = (inc[r] && !dec[r]) ? cnt[r] + 1'b1 :
                             (dec[r] && !inc[r]) ? cnt[r] - 1'b1 : cnt[r];
            o_busy_mask[r] = cnt[r] != '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_valid <= 1'b0;
            s_rdwen     <= 1'b0;
            s_rd        <= '0;
            s_wdata     <= '0;
            s_pc        <= '0;
            for (int r = 0; r < REG_COUNT; r++) cnt[r] <= '0;
        end else begin
            if (xfer) begin
                stage_valid <= 1'b1;
                s_rdwen     <= i_rdwen;
                s_rd        <= i_rdid;
                s_wdata     <= ext_data;
                s_pc        <= i_pc;
            end else if (retire) begin
                stage_valid <= 1'b0;
            end
            for (int r = 0; r < REG_COUNT; r++) cnt[r] <= cnt_nxt[r];
        end
    end

`ifdef WBU_INSTRET_EN
    logic [63:0] instret;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) instret <= '0;
        else if (retire) instret <= instret + 64'd1;
    end

    assign o_instret = instret;
`else
    assign o_instret = '0;
`endif

endmodule

// File: tb/tb_wbu_regwrite.sv
// tb_wbu_regwrite: directed table plus corner-case sequences for wbu_regwrite
module tb_wbu_regwrite;
    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_rdwen;
    logic [4:0]  i_rdid;
    logic        i_is_load;
    logic [2:0]  i_ld_func3;
    logic [63:0] i_alu_res;
    logic [63:0] i_ld_raw;
    logic [63:0] i_pc;
    logic        i_stall;
    logic        i_alloc;
    logic [4:0]  i_alloc_rd;
    logic        o_alloc_ready;
    logic [31:0] o_busy_mask;
    logic        o_wen;
    logic [4:0]  o_waddr;
    logic [63:0] o_wdata;
    logic        o_commit_valid;
    logic [63:0] o_commit_pc;
    logic [63:0] o_instret;

`ifdef WBU_INSTRET_EN
    localparam bit IEN = 1'b1;
`else
    localparam bit IEN = 1'b0;
`endif
    localparam int NV = 13;

    typedef struct {
        logic        rdwen;
        logic [4:0]  rd;
        logic        ld;
        logic [2:0]  f3;
        logic [63:0] alu;
        logic [63:0] raw;
        logic        ewen;
        logic [63:0] edata;
    } vec_t;

    vec_t v [NV];
    int   checks = 0;
    int   errors = 0;

    wbu_regwrite dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rdwen(i_rdwen), .i_rdid(i_rdid), .i_is_load(i_is_load), .i_ld_func3(i_ld_func3),
        .i_alu_res(i_alu_res), .i_ld_raw(i_ld_raw), .i_pc(i_pc), .i_stall(i_stall),
        .i_alloc(i_alloc), .i_alloc_rd(i_alloc_rd), .o_alloc_ready(o_alloc_ready),
        .o_busy_mask(o_busy_mask), .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_commit_valid(o_commit_valid), .o_commit_pc(o_commit_pc), .o_instret(o_instret)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdwen, input logic [4:0] rd, input logic ld,
                         input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] raw,
                         input logic [63:0] pc);
        i_valid    = 1'b1;
        i_rdwen    = rdwen;
        i_rdid     = rd;
        i_is_load  = ld;
        i_ld_func3 = f3;
        i_alu_res  = alu;
        i_ld_raw   = raw;
        i_pc       = pc;
    endtask

    initial begin
        v[0]  = '{1'b1, 5'd5,  1'b0, 3'b000, 64'h1234, 64'h0, 1'b1, 64'h1234};
        v[1]  = '{1'b1, 5'd6,  1'b1, 3'b000, 64'hFFFF, 64'hAAAA_5555_1234_5680, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        v[2]  = '{1'b1, 5'd6,  1'b1, 3'b100, 64'hFFFF, 64'hAAAA_5555_1234_5680, 1'b1, 64'h80};
        v[3]  = '{1'b1, 5'd8,  1'b1, 3'b010, 64'h0, 64'h1111_2222_8000_0000, 1'b1, 64'hFFFF_FFFF_8000_0000};
        v[4]  = '{1'b1, 5'd8,  1'b1, 3'b110, 64'h0, 64'h1111_2222_8000_0000, 1'b1, 64'h0000_0000_8000_0000};
        v[5]  = '{1'b1, 5'd9,  1'b1, 3'b001, 64'h0, 64'h0000_0000_1234_8001, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
        v[6]  = '{1'b1, 5'd9,  1'b1, 3'b101, 64'h0, 64'h0000_0000_1234_8001, 1'b1, 64'h8001};
        v[7]  = '{1'b1, 5'd10, 1'b1, 3'b011, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF};
        v[8]  = '{1'b1, 5'd31, 1'b1, 3'b111, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b1, 64'hFEDC_BA98_7654_3210};
        v[9]  = '{1'b1, 5'd0,  1'b0, 3'b000, 64'hDEAD, 64'h0, 1'b0, 64'hDEAD};
        v[10] = '{1'b0, 5'd12, 1'b0, 3'b000, 64'h55, 64'h0, 1'b0, 64'h55};
        v[11] = '{1'b1, 5'd13, 1'b0, 3'b000, 64'h80, 64'hFF, 1'b1, 64'h80};
        v[12] = '{1'b1, 5'd14, 1'b1, 3'b000, 64'h0, 64'h7F, 1'b1, 64'h7F};

        i_rst_n = 1'b1; i_valid = 1'b0; i_rdwen = 1'b0; i_rdid = '0; i_is_load = 1'b0;
        i_ld_func3 = '0; i_alu_res = '0; i_ld_raw = '0; i_pc = '0; i_stall = 1'b0;
        i_alloc = 1'b0; i_alloc_rd = '0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_wen", o_wen, 0);
        chk("rst_commit", o_commit_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_busy", o_busy_mask, 0);
        chk("rst_alloc_ready", o_alloc_ready, 1);
        chk("rst_waddr", o_waddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_pc", o_commit_pc, 0);
        chk("rst_instret", o_instret, 0);
        @(negedge i_clk) i_rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge i_clk);
            drive(v[k].rdwen, v[k].rd, v[k].ld, v[k].f3, v[k].alu, v[k].raw, 64'h8000_0000 + 64'(k * 4));
            @(posedge i_clk);
            #1;
            chk($sformatf("v%0d_wen", k), o_wen, v[k].ewen);
            chk($sformatf("v%0d_waddr", k), o_waddr, v[k].rd);
            chk($sformatf("v%0d_wdata", k), o_wdata, v[k].edata);
            chk($sformatf("v%0d_commit", k), o_commit_valid, 1);
            chk($sformatf("v%0d_pc", k), o_commit_pc, 64'h8000_0000 + 64'(k * 4));
            chk($sformatf("v%0d_ready", k), o_ready, 1);
            chk($sformatf("v%0d_busy", k), o_busy_mask, 0);
            chk($sformatf("v%0d_instret", k), o_instret, IEN ? 64'(k) : 64'd0);
        end
        @(negedge i_clk) i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        chk("drain_commit", o_commit_valid, 0);
        chk("drain_wen", o_wen, 0);
        chk("drain_waddr", o_waddr, 0);
        chk("drain_wdata", o_wdata, 0);
        chk("drain_instret", o_instret, IEN ? 64'(NV) : 64'd0);

        // stall: empty stage still accepts, full stage holds
        @(negedge i_clk);
        i_stall = 1'b1;
        drive(1'b1, 5'd10, 1'b0, 3'b000, 64'h5000, 64'h0, 64'h9000_0000);
        #1 chk("stall_empty_ready", o_ready, 1);
        @(posedge i_clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            drive(1'b1, 5'd11, 1'b0, 3'b000, 64'h6000, 64'h0, 64'h9000_0004);
            #1;
            chk($sformatf("stall%0d_ready", c), o_ready, 0);
            chk($sformatf("stall%0d_wen", c), o_wen, 0);
            chk($sformatf("stall%0d_commit", c), o_commit_valid, 0);
            chk($sformatf("stall%0d_wdata", c), o_wdata, 64'h5000);
        end
        @(negedge i_clk) i_stall = 1'b0;
        #1;
        chk("release_wen", o_wen, 1);
        chk("release_waddr", o_waddr, 10);
        chk("release_wdata", o_wdata, 64'h5000);
        chk("release_pc", o_commit_pc, 64'h9000_0000);
        chk("release_ready", o_ready, 1);
        chk("release_instret", o_instret, IEN ? 64'(NV) : 64'd0);
        for (int j = 0; j < 8; j++) begin
            @(negedge i_clk);
            if (j < 7) drive(1'b1, 5'(12 + j), 1'b0, 3'b000, 64'h6000 + 64'(j + 1), 64'h0,
                             64'h9000_0004 + 64'((j + 1) * 4));
            else i_valid = 1'b0;
            #1;
            chk($sformatf("b2b%0d_commit", j), o_commit_valid, 1);
            chk($sformatf("b2b%0d_wen", j), o_wen, 1);
            chk($sformatf("b2b%0d_waddr", j), o_waddr, 64'(11 + j));
            chk($sformatf("b2b%0d_wdata", j), o_wdata, 64'h6000 + 64'(j));
        end
        @(negedge i_clk);
        chk("b2b_drain_commit", o_commit_valid, 0);
        chk("b2b_instret", o_instret, IEN ? 64'(NV + 9) : 64'd0);

        // scoreboard
        i_alloc = 1'b1; i_alloc_rd = 5'd0;
        #1 chk("x0_alloc_ready", o_alloc_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            i_alloc_rd = 5'd7;
            #1;
            chk($sformatf("alloc%0d_ready", k), o_alloc_ready, 1);
            chk($sformatf("alloc%0d_busy", k), o_busy_mask, k == 0 ? 64'd0 : 64'h80);
        end
        @(negedge i_clk);
        chk("full_busy", o_busy_mask, 64'h80);
        chk("full_alloc_ready", o_alloc_ready, 0);
        i_alloc_rd = 5'd0;
        #1 chk("full_x0_ready", o_alloc_ready, 1);
        i_alloc_rd = 5'd7;
        @(negedge i_clk);
        i_alloc = 1'b0;
        drive(1'b1, 5'd7, 1'b0, 3'b000, 64'h71, 64'h0, 64'hA000_0000);
        @(negedge i_clk);
        chk("w1_wen", o_wen, 1);
        chk("w1_waddr", o_waddr, 7);
        i_alloc = 1'b1;
        i_alloc_rd = 5'd7;
        #1 chk("w1_alloc_ready", o_alloc_ready, 1);
        drive(1'b1, 5'd7, 1'b0, 3'b000, 64'h72, 64'h0, 64'hA000_0004);
        @(negedge i_clk);
        i_alloc = 1'b0;
        chk("w2_busy", o_busy_mask, 64'h80);
        drive(1'b1, 5'd7, 1'b0, 3'b000, 64'h73, 64'h0, 64'hA000_0008);
        @(negedge i_clk);
        drive(1'b1, 5'd7, 1'b0, 3'b000, 64'h74, 64'h0, 64'hA000_000C);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("w4_busy", o_busy_mask, 64'h80);
        chk("w4_wen", o_wen, 1);
        @(negedge i_clk);
        chk("sb_clear_busy", o_busy_mask, 0);
        chk("sb_instret", o_instret, IEN ? 64'(NV + 13) : 64'd0);

        // asynchronous reset in the middle of activity
        i_alloc = 1'b1; i_alloc_rd = 5'd5;
        @(negedge i_clk);
        @(negedge i_clk);
        i_alloc = 1'b0;
        drive(1'b1, 5'd3, 1'b0, 3'b000, 64'h77, 64'h0, 64'hB000_0000);
        @(negedge i_clk);
        chk("pre_rst_wen", o_wen, 1);
        chk("pre_rst_commit", o_commit_valid, 1);
        chk("pre_rst_busy", o_busy_mask, 64'h20);
        chk("pre_rst_instret", o_instret, IEN ? 64'(NV + 13) : 64'd0);
        i_stall = 1'b1;
        #1 chk("pre_rst_ready", o_ready, 0);
        #1 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", o_wen, 0);
        chk("mid_rst_commit", o_commit_valid, 0);
        chk("mid_rst_busy", o_busy_mask, 0);
        chk("mid_rst_instret", o_instret, 0);
        chk("mid_rst_ready", o_ready, 1);
        @(negedge i_clk) i_rst_n = 1'b1;
        #1;
        chk("post_rst_ready", o_ready, 1);
        chk("post_rst_wen", o_wen, 0);
        i_valid = 1'b0;
        i_stall = 1'b0;
        @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
